// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_RSP = 2'd1, DROP = 2'd2} fetch_state_t;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
endpackage

// File: rtl/ifid_slot.sv
// One-entry IF/ID register: load from the fetch FSM, consume by decode, flush on redirect.
module ifid_slot #(
  parameter int                    AW  = 32,
  parameter int                    DW  = 32,
  parameter logic [DW-1:0]         NOP = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [AW-1:0] ld_pc_i,
  input  logic [DW-1:0] ld_instr_i,
  input  logic          ld_mis_i,
  input  logic          flush_i,
  input  logic          ready_i,
  output logic          valid_o,
  output logic [AW-1:0] pc_o,
  output logic [DW-1:0] instr_o,
  output logic          mis_o
);
  logic          valid_q, valid_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] instr_q, instr_d;
  logic          mis_q, mis_d;

  // Priority: consume, then refill on the same edge, then flush wins over both.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    mis_d   = mis_q;
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
      instr_d = NOP;
      mis_d   = 1'b0;
    end
    if (load_i) begin
      valid_d = 1'b1;
      pc_d    = ld_pc_i;
      instr_d = ld_instr_i;
      mis_d   = ld_mis_i;
    end
    if (flush_i) begin
      valid_d = 1'b0;
      instr_d = NOP;
      mis_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOP;
      mis_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      mis_q   <= mis_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign mis_o   = mis_q;
endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: one outstanding imem request, response parked in the IF/ID slot for decode.
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                      ADDRESS_WIDTH = 32,
  parameter int                      DATA_WIDTH    = 32,
  parameter logic [DATA_WIDTH-1:0]   NOP_INSTR     = DATA_WIDTH'(NOP_INSTR_DEF)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] pc_i,
  output logic                     pc_advance_o,
  input  logic                     flush_i,
  output logic                     imem_req_o,
  output logic [ADDRESS_WIDTH-1:0] imem_addr_o,
  input  logic                     imem_gnt_i,
  input  logic                     imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]    imem_rdata_i,
  output logic                     if_valid_o,
  output logic [ADDRESS_WIDTH-1:0] if_pc_o,
  output logic [DATA_WIDTH-1:0]    if_instr_o,
  output logic                     if_misalign_o,
  input  logic                     id_ready_i,
  output fetch_state_t             dbg_state_o
);
  // Handshakes: an imem request transfers on a cycle where imem_req_o & imem_gnt_i;
  // an ungranted request may be withdrawn. The IF/ID slot transfers to decode on a
  // cycle where if_valid_o & id_ready_i; while valid and not ready its payload is frozen.
  fetch_state_t             state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                     req_mis_q, req_mis_d;
  logic                     imem_req;
  logic                     slot_load;

  always_comb begin
    state_d   = state_q;
    req_pc_d  = req_pc_q;
    req_mis_d = req_mis_q;
    imem_req  = 1'b0;
    slot_load = 1'b0;
    case (state_q)
      IDLE: begin
        imem_req = ~flush_i & (~if_valid_o | id_ready_i);
        if (imem_req && imem_gnt_i) begin
          state_d   = WAIT_RSP;
          req_pc_d  = pc_i;
          req_mis_d = |pc_i[1:0];
        end
      end
      WAIT_RSP: begin
        if (imem_rvalid_i) begin
          slot_load = ~flush_i;
          state_d   = IDLE;
        end else if (flush_i) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!rst) begin
      imem_req  = 1'b0;
      slot_load = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      req_pc_q  <= '0;
      req_mis_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_pc_q  <= req_pc_d;
      req_mis_q <= req_mis_d;
    end
  end

  assign imem_req_o   = imem_req;
  assign pc_advance_o = imem_req & imem_gnt_i;
  assign imem_addr_o  = {pc_i[ADDRESS_WIDTH-1:2], 2'b00};
  assign dbg_state_o  = state_q;

  ifid_slot #(
    .AW  (ADDRESS_WIDTH),
    .DW  (DATA_WIDTH),
    .NOP (NOP_INSTR)
  ) u_slot (
    .clk        (clk),
    .rst        (rst),
    .load_i     (slot_load),
    .ld_pc_i    (req_pc_q),
    .ld_instr_i (imem_rdata_i),
    .ld_mis_i   (req_mis_q),
    .flush_i    (flush_i),
    .ready_i    (id_ready_i),
    .valid_o    (if_valid_o),
    .pc_o       (if_pc_o),
    .instr_o    (if_instr_o),
    .mis_o      (if_misalign_o)
  );
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: vector table, directed corner sequences, random run against a transaction model.
module tb_if_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic         clk;
  logic         rst;
  logic [31:0]  pc_i;
  logic         pc_advance;
  logic         flush;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_gnt;
  logic         imem_rvalid;
  logic [31:0]  imem_rdata;
  logic         if_valid;
  logic [31:0]  if_pc;
  logic [31:0]  if_instr;
  logic         if_mis;
  logic         id_ready;
  fetch_state_t dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .pc_i          (pc_i),
    .pc_advance_o  (pc_advance),
    .flush_i       (flush),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_gnt_i    (imem_gnt),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .if_valid_o    (if_valid),
    .if_pc_o       (if_pc),
    .if_instr_o    (if_instr),
    .if_misalign_o (if_mis),
    .id_ready_i    (id_ready),
    .dbg_state_o   (dbg_state)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: inputs change on the falling edge, outputs sampled 1 ns later
  task automatic step(input logic r, input logic f, input logic g, input logic rv,
                      input logic [31:0] rd, input logic [31:0] pc, input logic rdy);
    @(negedge clk);
    rst = r; flush = f; imem_gnt = g; imem_rvalid = rv;
    imem_rdata = rd; pc_i = pc; id_ready = rdy;
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
  endtask

  typedef struct {
    logic        rst;
    logic        flush;
    logic        gnt;
    logic [31:0] pc;
    logic        exp_req;
    logic        exp_adv;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t tbl[8];

  // scoreboard state for the random run: {mis, pc, instr}
  logic [64:0] exp_q[$];

  initial begin
    logic        busy, killed, f, g, rv, rdy, exp_req;
    logic [31:0] cur_pc, pend_pc, rd;
    logic [64:0] ent;
    int          cnt, adv_count;

    tbl[0] = '{1'b0, 1'b0, 1'b1, 32'h0000_1234, 1'b0, 1'b0, 32'h0000_1234};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 32'h0000_0008, 1'b0, 1'b0, 32'h0000_0008};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0100};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 32'h0000_0022, 1'b1, 1'b0, 32'h0000_0020};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFC};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h0000_0040, 1'b0, 1'b0, 32'h0000_0040};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 32'h0000_0044, 1'b0, 1'b0, 32'h0000_0044};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 32'h0000_0004, 1'b0, 1'b0, 32'h0000_0004};

    rst = 1'b0; flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = '0; pc_i = '0; id_ready = 1'b1;

    // reset held with a grant offered: nothing may issue
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h1000, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h1000, 1'b1);
    chk1("rst_valid", if_valid, 1'b0);
    chk32("rst_instr", if_instr, NOP);
    chk32("rst_pc", if_pc, 32'h0);
    chk1("rst_mis", if_mis, 1'b0);
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_adv", pc_advance, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h1000, 1'b1);
    chk1("post_rst_req", imem_req, 1'b1);
    chk32("post_rst_addr", imem_addr, 32'h1000);

    // idle request gating table (no grant ever lands, so state stays IDLE)
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].rst, tbl[i].flush, tbl[i].gnt, 1'b0, 32'h0, tbl[i].pc, 1'b1);
      chk1($sformatf("tbl%0d_req", i), imem_req, tbl[i].exp_req);
      chk1($sformatf("tbl%0d_adv", i), pc_advance, tbl[i].exp_adv);
      chk32($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].exp_addr);
      chk1($sformatf("tbl%0d_valid", i), if_valid, 1'b0);
    end

    // streaming with a 1-cycle memory
    do_reset();
    adv_count = 0;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'(k * 4), 1'b1);
      chk1("strm_req", imem_req, 1'b1);
      chk32("strm_addr", imem_addr, 32'(k * 4));
      if (pc_advance) adv_count++;
      if (k > 0) begin
        chk1("strm_valid", if_valid, 1'b1);
        chk32("strm_pc", if_pc, 32'((k - 1) * 4));
        chk32("strm_instr", if_instr, mem(32'((k - 1) * 4)));
      end
      step(1'b1, 1'b0, 1'b1, 1'b1, mem(32'(k * 4)), 32'(k * 4 + 4), 1'b1);
      chk1("strm_wait_req", imem_req, 1'b0);
      if (pc_advance) adv_count++;
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'd12, 1'b1);
    chk1("strm_last_valid", if_valid, 1'b1);
    chk32("strm_last_pc", if_pc, 32'd8);
    chk32("strm_last_instr", if_instr, mem(32'd8));
    chk32("strm_adv_count", 32'(adv_count), 32'd3);

    // backpressure: full slot stalled for 5 cycles
    do_reset();
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h40, 1'b0);
    chk1("bp_adv", pc_advance, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1, mem(32'h40), 32'h44, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h44, 1'b0);
      chk1("bp_req", imem_req, 1'b0);
      chk1("bp_adv_stall", pc_advance, 1'b0);
      chk1("bp_valid", if_valid, 1'b1);
      chk32("bp_pc", if_pc, 32'h40);
      chk32("bp_instr", if_instr, mem(32'h40));
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h44, 1'b1);
    chk1("bp_drain_req", imem_req, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h44, 1'b1);
    chk1("bp_after_valid", if_valid, 1'b0);
    chk1("bp_after_adv", pc_advance, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, mem(32'h44), 32'h48, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h48, 1'b1);
    chk32("bp_next_pc", if_pc, 32'h44);

    // flush while waiting for a response
    do_reset();
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h10, 1'b1);
    chk1("fw_adv", pc_advance, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h80, 1'b1);
    chk32("fw_state_wait", 32'(dbg_state), 32'(WAIT_RSP));
    chk1("fw_req0", imem_req, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h80, 1'b1);
    chk32("fw_state_drop", 32'(dbg_state), 32'(DROP));
    chk1("fw_req1", imem_req, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h80, 1'b1);
    chk1("fw_req2", imem_req, 1'b0);
    chk1("fw_adv2", pc_advance, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h80, 1'b1);
    chk1("fw_valid", if_valid, 1'b0);
    chk32("fw_instr", if_instr, NOP);
    chk1("fw_req3", imem_req, 1'b1);
    chk32("fw_addr", imem_addr, 32'h80);

    // flush coincident with rvalid, then flush against an ungranted request
    do_reset();
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h30, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h1234_5678, 32'h90, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h90, 1'b1);
    chk1("fc_valid", if_valid, 1'b0);
    chk32("fc_instr", if_instr, NOP);
    chk1("fc_req", imem_req, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h94, 1'b1);
    chk1("fu_req", imem_req, 1'b0);
    chk1("fu_adv", pc_advance, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h94, 1'b1);
    chk32("fu_state", 32'(dbg_state), 32'(IDLE));
    // flush of a full, stalled slot
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h50, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, mem(32'h50), 32'h54, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'hA0, 1'b0);
    chk1("fs_valid_before", if_valid, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'hA0, 1'b0);
    chk1("fs_valid_after", if_valid, 1'b0);
    chk32("fs_instr_after", if_instr, NOP);

    // misaligned PC, then reset in WAIT_RSP with a late response
    do_reset();
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h22, 1'b0);
    chk32("mis_addr", imem_addr, 32'h20);
    chk1("mis_adv", pc_advance, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, mem(32'h20), 32'h26, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h26, 1'b1);
    chk1("mis_valid", if_valid, 1'b1);
    chk32("mis_pc", if_pc, 32'h22);
    chk1("mis_flag", if_mis, 1'b1);
    chk32("mis_instr", if_instr, mem(32'h20));
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h60, 1'b1);
    chk1("rr_adv", pc_advance, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h64, 1'b1);
    chk1("rr_req_in_rst", imem_req, 1'b0);
    chk1("rr_adv_in_rst", pc_advance, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h64, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'hBAD0_BAD0, 32'h64, 1'b1);
    chk1("rr_req_after", imem_req, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h64, 1'b1);
    chk1("rr_valid", if_valid, 1'b0);
    chk32("rr_instr", if_instr, NOP);

    // random traffic against a transaction-level model
    do_reset();
    busy = 1'b0; killed = 1'b0; cnt = 0; cur_pc = 32'h0; pend_pc = 32'h0;
    exp_q.delete();
    for (int i = 0; i < 3000; i++) begin
      f   = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      g   = ($urandom_range(0, 2) != 0);
      rv  = busy && (cnt == 0);
      rd  = rv ? mem({pend_pc[31:2], 2'b00}) : $urandom;
      if (busy && cnt != 0) cnt--;
      step(1'b1, f, g, rv, rd, cur_pc, rdy);

      exp_req = !busy && !f && (exp_q.size() == 0 || rdy);
      chk1("rnd_req", imem_req, exp_req);
      chk1("rnd_adv", pc_advance, exp_req & g);
      chk1("rnd_valid", if_valid, exp_q.size() != 0);
      if (imem_req) chk32("rnd_addr", imem_addr, {cur_pc[31:2], 2'b00});
      if (exp_q.size() != 0) begin
        ent = exp_q[0];
        chk32("rnd_pc", if_pc, ent[63:32]);
        chk32("rnd_instr", if_instr, ent[31:0]);
        chk1("rnd_mis", if_mis, ent[64]);
        if (rdy) void'(exp_q.pop_front());
      end else begin
        chk32("rnd_nop", if_instr, NOP);
      end

      if (f) exp_q.delete();
      if (rv) begin
        busy = 1'b0;
        if (!killed && !f) exp_q.push_back({|pend_pc[1:0], pend_pc, rd});
      end
      if (f && busy) killed = 1'b1;
      if (exp_req && g) begin
        busy    = 1'b1;
        killed  = 1'b0;
        pend_pc = cur_pc;
        cnt     = $urandom_range(0, 2);
        cur_pc  = cur_pc + 32'd4;
      end
      if (f) begin
        cur_pc = 32'($urandom_range(0, 65535));
        if ($urandom_range(0, 3) != 0) cur_pc[1:0] = 2'b00;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
